mining_controller: RTL and testbench
====================================

Name: mining_controller

Overview:
- Initiator side of the hashing-module handshake: drives begin_hash and quit_hash, and consumes hash_done plus the resulting hash.
- Sweeps nonces from nonce_start to nonce_end, issuing one hash per nonce.
- Compares each hash (unsigned) against target and reports found, exhausted or timeout.
- Sits between the host/top-level I/O interface and the hashing module.

Parameters:
NONCE_WIDTH, 32, width of nonce counter and nonce range inputs
HASH_WIDTH, 256, width of hash result and target
TIMEOUT_CYCLES, 300, maximum cycles WAIT_HASH waits for hash_done before aborting

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start_mining  input  1  level; accepted only in IDLE
stop_mining  input  1  abort request; highest priority
nonce_start  input  NONCE_WIDTH  first nonce; sampled when start is accepted
nonce_end  input  NONCE_WIDTH  last nonce, inclusive; sampled when start is accepted
target  input  HASH_WIDTH  difficulty target; must be stable while busy
hash_done  input  1  one-cycle pulse from the hashing module
hash_in  input  HASH_WIDTH  hash result; valid in the hash_done cycle
begin_hash  output  1  one-cycle pulse starting a hash
quit_hash  output  1  one-cycle pulse aborting an in-flight hash
nonce  output  NONCE_WIDTH  nonce currently being hashed, or the winning nonce
win_hash  output  HASH_WIDTH  latched hash of the winning nonce
busy  output  1  high in every state except IDLE
nonce_found  output  1  sticky result flag
exhausted  output  1  sticky result flag
timeout_err  output  1  sticky result flag

Behaviour:
- Reset (asynchronous): state=IDLE; nonce=0; win_hash=0; internal hash register=0; timer=0. All 1-bit outputs are 0.
- States: IDLE, ISSUE, WAIT_HASH, COMPARE, ABORT. Next state is registered; begin_hash, quit_hash and busy are decoded from state (Moore).
- IDLE:
  - start_mining=1 and stop_mining=0 → register nonce<=nonce_start and end_reg<=nonce_end, clear all three sticky flags, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - begin_hash=1 for exactly this cycle; timer<=0.
  - Next state is WAIT_HASH.
- WAIT_HASH:
  - timer increments each cycle.
  - hash_done=1 → hash_reg<=hash_in, go to COMPARE.
  - Otherwise, timer==TIMEOUT_CYCLES-1 → timeout_err<=1, go to ABORT.
  - hash_done in the same cycle as the timeout condition: hash_done wins, no error.
- COMPARE: one cycle, unsigned full-width comparison.
  - hash_reg < target → nonce_found<=1, win_hash<=hash_reg, nonce is held, go to IDLE.
  - hash_reg == target counts as a miss.
  - Else nonce==end_reg → exhausted<=1, go to IDLE; nonce holds the last value tried.
  - Else nonce<=nonce+1, modulo 2^NONCE_WIDTH, go to ISSUE.
- ABORT:
  - quit_hash=1 for exactly this cycle.
  - Next state is IDLE.
- Nonce range and wrap:
  - nonce_end < nonce_start is legal; the sweep wraps through 0.
  - nonce_start==nonce_end gives exactly one hash.
  - Termination is by equality only.
- stop_mining overrides every other transition, including hash_done and the found result:
  - In WAIT_HASH → go to ABORT; no flag is set.
  - In ISSUE or COMPARE → go straight to IDLE without quit_hash; no flag is set.
  - In IDLE, stop_mining blocks start_mining.
- start_mining while busy is ignored.
- Sticky flags hold in IDLE until the next accepted start. At most one flag is ever set per run.
- Latency:
  - Start accepted at edge N → begin_hash high in cycle N+1.
  - hash_done in cycle M → COMPARE in M+1 → next begin_hash in M+2.
  - A found or exhausted result reaches the flag output in the cycle after COMPARE.
- hash_done outside WAIT_HASH is ignored.
- Asynchronous reset mid-sweep returns every register to its reset value immediately; quit_hash is not emitted.

Test Plan:
- Single hit: nonce_start=5, nonce_end=9, target=2^255, respond with hash=2^254 for nonce 7 and hash=2^256-1 otherwise, 20 cycles after each begin_hash → exactly 3 begin_hash pulses; nonce_found=1; nonce=7; win_hash=2^254; busy=0.
- Exhaust with wrap: nonce_start=0xFFFFFFFE, nonce_end=0x00000001, all hashes ≥ target → 4 begin_hash pulses at nonces FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1; nonce=1.
- Equality boundary: hash_in==target on a single-nonce range (start=end=0x10) → exhausted=1 and nonce_found=0.
- Timeout: never assert hash_done → quit_hash pulses exactly TIMEOUT_CYCLES+1 cycles after begin_hash; timeout_err=1. Repeat with hash_done in the final WAIT_HASH cycle → no timeout, COMPARE is taken.
- Stop: assert stop_mining in the 10th WAIT_HASH cycle, then in an ISSUE cycle → ABORT with one quit_hash pulse in the first case, none in the second; all flags 0; start_mining during busy has no effect.
- Reset mid-sweep, then restart with start=3, end=3 → outputs zero immediately, and the new run yields begin_hash at N+1 with nonce=3.

Source files
------------

// File: rtl/mining_controller.sv
// Nonce-sweep controller driving the hashing module handshake.
// Issues one hash per nonce and reports found, exhausted or timeout.
module mining_controller #(
  parameter int NONCE_WIDTH    = 32,
  parameter int HASH_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_mining,
  input  logic                   stop_mining,
  input  logic [NONCE_WIDTH-1:0] nonce_start,
  input  logic [NONCE_WIDTH-1:0] nonce_end,
  input  logic [HASH_WIDTH-1:0]  target,
  input  logic                   hash_done,
  input  logic [HASH_WIDTH-1:0]  hash_in,
  output logic                   begin_hash,
  output logic                   quit_hash,
  output logic [NONCE_WIDTH-1:0] nonce,
  output logic [HASH_WIDTH-1:0]  win_hash,
  output logic                   busy,
  output logic                   nonce_found,
  output logic                   exhausted,
  output logic                   timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HASH,
    COMPARE,
    ABORT
  } state_t;

  state_t                 state;
  logic [NONCE_WIDTH-1:0] end_reg;
  logic [HASH_WIDTH-1:0]  hash_reg;
  logic [TW-1:0]          timer;

  assign begin_hash = (state == ISSUE);
  assign quit_hash  = (state == ABORT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      nonce       <= '0;
      end_reg     <= '0;
      win_hash    <= '0;
      hash_reg    <= '0;
      timer       <= '0;
      nonce_found <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_mining && !stop_mining) begin
            nonce       <= nonce_start;
            end_reg     <= nonce_end;
            nonce_found <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= stop_mining ? IDLE : WAIT_HASH;
        end
        WAIT_HASH: begin
          timer <= timer + TW'(1);
          // stop beats a completing hash; a completing hash beats timeout
          if (stop_mining) begin
            state <= ABORT;
          end else if (hash_done) begin
            hash_reg <= hash_in;
            state    <= COMPARE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= ABORT;
          end
        end
        COMPARE: begin
          if (stop_mining) begin
            state <= IDLE;
          end else if (hash_reg < target) begin
            nonce_found <= 1'b1;
            win_hash    <= hash_reg;
            state       <= IDLE;
          end else if (nonce == end_reg) begin
            exhausted <= 1'b1;
            state     <= IDLE;
          end else begin
            nonce <= nonce + NONCE_WIDTH'(1);
            state <= ISSUE;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mining_controller.sv
// Scoreboard bench for mining_controller with a behavioural hasher.
// Expected nonces are queued per run and popped on each begin_hash.
module tb_mining_controller;

  localparam int NW = 32;
  localparam int HW = 256;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_mining = 1'b0;
  logic          stop_mining = 1'b0;
  logic [NW-1:0] nonce_start = '0;
  logic [NW-1:0] nonce_end = '0;
  logic [HW-1:0] target = '0;
  logic          hash_done = 1'b0;
  logic [HW-1:0] hash_in = '0;
  logic          begin_hash;
  logic          quit_hash;
  logic [NW-1:0] nonce;
  logic [HW-1:0] win_hash;
  logic          busy;
  logic          nonce_found;
  logic          exhausted;
  logic          timeout_err;

  mining_controller #(
    .NONCE_WIDTH(NW),
    .HASH_WIDTH(HW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start_mining(start_mining),
    .stop_mining(stop_mining),
    .nonce_start(nonce_start),
    .nonce_end(nonce_end),
    .target(target),
    .hash_done(hash_done),
    .hash_in(hash_in),
    .begin_hash(begin_hash),
    .quit_hash(quit_hash),
    .nonce(nonce),
    .win_hash(win_hash),
    .busy(busy),
    .nonce_found(nonce_found),
    .exhausted(exhausted),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [NW-1:0] exp_q[$];

  int            cyc = 0;
  int            cnt = 0;
  int            resp_delay = 20;
  logic          hit_en = 1'b0;
  logic [NW-1:0] hit_nonce = '0;
  logic [HW-1:0] hit_val = '0;
  logic [HW-1:0] miss_val = '1;
  logic [NW-1:0] pend_nonce = '0;
  int            begin_cnt = 0;
  int            quit_cnt = 0;
  int            last_begin = 0;
  int            prev_begin = 0;
  int            quit_cyc = 0;

  task automatic chk(input string tag, input logic [HW-1:0] got,
                     input logic [HW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [HW-1:0] hash_for(input logic [NW-1:0] n);
    if (hit_en && n == hit_nonce) return hit_val;
    return miss_val;
  endfunction

  // hasher model and begin/quit monitor
  always @(posedge clk) begin
    #1;
    cyc++;
    hash_done = 1'b0;
    if (!n_rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          hash_done = 1'b1;
          hash_in   = hash_for(pend_nonce);
        end
      end
      if (begin_hash) begin
        pend_nonce = nonce;
        cnt        = resp_delay;
        begin_cnt++;
        prev_begin = last_begin;
        last_begin = cyc;
        if (exp_q.size() == 0) chk("extra_begin", nonce, '1);
        else chk("begin_nonce", nonce, exp_q.pop_front());
      end
      if (quit_hash) begin
        quit_cnt++;
        quit_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [NW-1:0] s, input logic [NW-1:0] e);
    nonce_start  = s;
    nonce_end    = e;
    start_mining = 1'b1;
    tick();
    start_mining = 1'b0;
    chk("lat_begin", begin_hash, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    chk("idle_bound", busy, 1'b0);
    tick();
  endtask

  task automatic flags(input string tag, input logic f, input logic x,
                       input logic t);
    chk({tag, "_found"}, nonce_found, f);
    chk({tag, "_exh"}, exhausted, x);
    chk({tag, "_tout"}, timeout_err, t);
  endtask

  int b0;
  int q0;

  initial begin
    target = 256'h1 << 255;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_nonce", nonce, '0);
    chk("rst_win", win_hash, '0);
    chk("rst_pulses", {begin_hash, quit_hash}, 2'b00);
    flags("rst", 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    tick();

    // single hit at nonce 7
    hit_en = 1'b1;
    hit_nonce = 32'd7;
    hit_val = 256'h1 << 254;
    miss_val = '1;
    resp_delay = 20;
    b0 = begin_cnt;
    exp_q = '{32'd5, 32'd6, 32'd7};
    start_run(32'd5, 32'd9);
    wait_idle(200);
    chk("hit_begins", begin_cnt - b0, 3);
    chk("hit_gap", last_begin - prev_begin, 22);
    chk("hit_nonce", nonce, 32'd7);
    chk("hit_win", win_hash, 256'h1 << 254);
    flags("hit", 1'b1, 1'b0, 1'b0);
    chk("hit_sb", exp_q.size(), 0);

    // exhaust with wrap through zero
    hit_en = 1'b0;
    b0 = begin_cnt;
    exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    start_run(32'hFFFF_FFFE, 32'h1);
    wait_idle(200);
    chk("wrap_begins", begin_cnt - b0, 4);
    chk("wrap_nonce", nonce, 32'h1);
    flags("wrap", 1'b0, 1'b1, 1'b0);
    chk("wrap_sb", exp_q.size(), 0);

    // hash equal to target is a miss
    target = {8{32'h1234_5678}};
    miss_val = target;
    b0 = begin_cnt;
    exp_q = '{32'h10};
    start_run(32'h10, 32'h10);
    wait_idle(100);
    chk("eq_begins", begin_cnt - b0, 1);
    flags("eq", 1'b0, 1'b1, 1'b0);
    target = 256'h1 << 255;
    miss_val = '1;

    // timeout without hash_done
    resp_delay = 0;
    q0 = quit_cnt;
    exp_q = '{32'h20};
    start_run(32'h20, 32'h20);
    wait_idle(400);
    chk("to_quits", quit_cnt - q0, 1);
    chk("to_delay", quit_cyc - last_begin, TO + 1);
    chk("to_nonce", nonce, 32'h20);
    flags("to", 1'b0, 1'b0, 1'b1);

    // hash_done in the final wait cycle wins
    resp_delay = TO;
    q0 = quit_cnt;
    exp_q = '{32'h21};
    start_run(32'h21, 32'h21);
    wait_idle(400);
    chk("late_quits", quit_cnt - q0, 0);
    flags("late", 1'b0, 1'b1, 1'b0);

    // stop in the 10th wait cycle, with start ignored while busy
    resp_delay = 0;
    q0 = quit_cnt;
    exp_q = '{32'h0};
    start_run(32'h0, 32'd100);
    nonce_start = 32'h55;
    start_mining = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    start_mining = 1'b0;
    stop_mining = 1'b1;
    tick();
    chk("stopw_quit", quit_hash, 1'b1);
    stop_mining = 1'b0;
    tick();
    tick();
    chk("stopw_busy", busy, 1'b0);
    chk("stopw_quits", quit_cnt - q0, 1);
    chk("stopw_nonce", nonce, 32'h0);
    flags("stopw", 1'b0, 1'b0, 1'b0);

    // stop in issue; later hash_done while idle is ignored
    resp_delay = 5;
    q0 = quit_cnt;
    b0 = begin_cnt;
    exp_q = '{32'h40};
    start_run(32'h40, 32'h50);
    stop_mining = 1'b1;
    tick();
    chk("stopi_busy", busy, 1'b0);
    stop_mining = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stopi_idle", busy, 1'b0);
    chk("stopi_quits", quit_cnt - q0, 0);
    chk("stopi_begins", begin_cnt - b0, 1);
    flags("stopi", 1'b0, 1'b0, 1'b0);

    // stop blocks start in idle
    start_mining = 1'b1;
    stop_mining = 1'b1;
    tick();
    chk("block_busy", busy, 1'b0);
    start_mining = 1'b0;
    stop_mining = 1'b0;
    tick();

    // async reset mid-sweep, then restart
    resp_delay = 20;
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};
    start_run(32'd0, 32'd100);
    for (int i = 0; i < 30; i++) tick();
    q0 = quit_cnt;
    #2;
    n_rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_nonce", nonce, '0);
    chk("mrst_win", win_hash, '0);
    chk("mrst_pulses", {begin_hash, quit_hash}, 2'b00);
    exp_q.delete();
    tick();
    n_rst = 1'b1;
    tick();
    chk("mrst_quits", quit_cnt - q0, 0);
    exp_q = '{32'd3};
    start_run(32'd3, 32'd3);
    chk("mrst_nonce3", nonce, 32'd3);
    wait_idle(100);
    flags("mrst", 1'b0, 1'b1, 1'b0);
    chk("mrst_sb", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
